// File: rtl/cache_miss_ctrl.sv
// ---------------------------------------------------------------------------
// cache_miss_ctrl
//
// Sequencing controller for one set-associative cache lookup path. It holds
// no tag or data storage. It classifies each CPU request as a hit or a miss,
// pulses the replacement unit's enable, writes back a dirty victim, refills
// the line one word at a time, then looks the line up again and responds.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cpu_req_i/we_i/addr_i  CPU request, sampled in IDLE only
//   cpu_ready_o            one-cycle completion pulse
//   hit/valid/dirty_line_i per-way status of the indexed set (from arrays)
//   repl_en_o, repl_line_i replacement-unit enable and one-hot victim
//   victim_addr_i          line base address of the way chosen by line_sel_o
//   line_sel_o             one-hot way select to the arrays
//   req_addr_o             latched CPU address (array index/tag)
//   word_idx_o             word within the line for fill/writeback
//   fill_we_o, tag_we_o    refill word write, tag write (valid=1, dirty=0)
//   dirty_set_o            mark selected way dirty (write hit)
//   mem_req/we/addr_o      memory word request, direction and byte address
//   mem_ack_i              memory completed the current word
//   hit_cnt_o, miss_cnt_o  saturating statistics counters
// ---------------------------------------------------------------------------
module cache_miss_ctrl #(
  parameter int unsigned SET_SIZE   = 4,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cpu_req_i,
  input  logic                          cpu_we_i,
  input  logic [ADDR_WIDTH-1:0]         cpu_addr_i,
  output logic                          cpu_ready_o,
  input  logic [SET_SIZE-1:0]           hit_line_i,
  input  logic [SET_SIZE-1:0]           valid_line_i,
  input  logic [SET_SIZE-1:0]           dirty_line_i,
  output logic                          repl_en_o,
  input  logic [SET_SIZE-1:0]           repl_line_i,
  input  logic [ADDR_WIDTH-1:0]         victim_addr_i,
  output logic [SET_SIZE-1:0]           line_sel_o,
  output logic [ADDR_WIDTH-1:0]         req_addr_o,
  output logic [$clog2(LINE_WORDS)-1:0] word_idx_o,
  output logic                          fill_we_o,
  output logic                          tag_we_o,
  output logic                          dirty_set_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  input  logic                          mem_ack_i,
  output logic [31:0]                   hit_cnt_o,
  output logic [31:0]                   miss_cnt_o
);

  localparam int unsigned WIDX_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = $clog2(4 * LINE_WORDS);
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_REFILL,
    S_RESPOND
  } state_e;

  state_e                  state_q,     state_d;
  logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
  logic                    we_q,        we_d;
  logic [SET_SIZE-1:0]     victim_q,    victim_d;
  logic [WIDX_W-1:0]       word_cnt_q,  word_cnt_d;
  // Set once the refill has completed, so the second lookup of the same
  // request does not count as another hit or miss.
  logic                    relookup_q,  relookup_d;
  logic [31:0]             hit_cnt_q,   hit_cnt_d;
  logic [31:0]             miss_cnt_q,  miss_cnt_d;
  logic                    cpu_ready_q, cpu_ready_d;
  logic                    repl_en_q,   repl_en_d;
  logic                    mem_req_q,   mem_req_d;
  logic                    mem_we_q,    mem_we_d;

  logic                    lookup_hit;
  logic                    victim_dirty;
  logic                    last_word;
  logic [ADDR_WIDTH-1:0]   word_off;
  logic [ADDR_WIDTH-1:0]   line_base;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign lookup_hit   = |hit_line_i;
  // Only a victim that is both valid and dirty needs writing back.
  assign victim_dirty = |(repl_line_i & valid_line_i & dirty_line_i);
  assign last_word    = (word_cnt_q == LAST_WORD);
  assign word_off     = ADDR_WIDTH'({word_cnt_q, 2'b00});
  assign line_base    = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  // Next-state and next-register computation.
  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    victim_d   = victim_q;
    word_cnt_d = word_cnt_q;
    relookup_d = relookup_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req_i) begin
          addr_d     = cpu_addr_i;
          we_d       = cpu_we_i;
          relookup_d = 1'b0;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lookup_hit) begin
          if (!relookup_q) hit_cnt_d = sat_inc(hit_cnt_q);
          state_d = S_RESPOND;
        end else begin
          victim_d = repl_line_i;
          if (!relookup_q) miss_cnt_d = sat_inc(miss_cnt_q);
          state_d = victim_dirty ? S_WRITEBACK : S_REFILL;
        end
      end
      S_WRITEBACK: begin
        if (mem_ack_i) begin
          // LINE_WORDS is a power of two, so the counter wraps to 0 itself.
          word_cnt_d = word_cnt_q + WIDX_W'(1);
          if (last_word) state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_ack_i) begin
          word_cnt_d = word_cnt_q + WIDX_W'(1);
          if (last_word) begin
            relookup_d = 1'b1;
            state_d    = S_LOOKUP;
          end
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Moore outputs are registered from the next state so they are glitch
    // free and drop immediately with the asynchronous reset.
    cpu_ready_d = (state_d == S_RESPOND);
    repl_en_d   = (state_d == S_LOOKUP);
    mem_req_d   = (state_d == S_WRITEBACK) || (state_d == S_REFILL);
    mem_we_d    = (state_d == S_WRITEBACK);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others.
  // NOTE: every flop is reset, including the latched request registers,
  // so all outputs read 0 straight out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      victim_q    <= '0;
      word_cnt_q  <= '0;
      relookup_q  <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      cpu_ready_q <= 1'b0;
      repl_en_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      victim_q    <= victim_d;
      word_cnt_q  <= word_cnt_d;
      relookup_q  <= relookup_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      cpu_ready_q <= cpu_ready_d;
      repl_en_q   <= repl_en_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
    end
  end

  // Outputs that follow array/memory inputs in the same cycle.
  always_comb begin
    line_sel_o  = '0;
    dirty_set_o = 1'b0;
    mem_addr_o  = '0;
    fill_we_o   = 1'b0;
    tag_we_o    = 1'b0;

    unique case (state_q)
      S_LOOKUP: begin
        if (lookup_hit) begin
          line_sel_o  = hit_line_i;
          dirty_set_o = we_q;
        end
      end
      S_WRITEBACK: begin
        line_sel_o = victim_q;
        mem_addr_o = victim_addr_i + word_off;
      end
      S_REFILL: begin
        line_sel_o = victim_q;
        mem_addr_o = line_base + word_off;
        fill_we_o  = mem_ack_i;
        // Tag is written together with the last data word.
        tag_we_o   = mem_ack_i & last_word;
      end
      default: ;
    endcase
  end

  assign cpu_ready_o = cpu_ready_q;
  assign repl_en_o   = repl_en_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign req_addr_o  = addr_q;
  assign word_idx_o  = word_cnt_q;
  assign hit_cnt_o   = hit_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;

endmodule
